pdp8_mem_arb: RTL and testbench

- Arbitrates the external 256Kx16 SRAM between two requesters: the CPU memory port and the RF08 disk data-break (DMA) port.
- Sequences each SRAM access as a multi-cycle read or write, and maps the 15-bit PDP-8 field:address onto the SRAM address bus.
- Sits inside top, between pdp8/pdp8_rf and the sram_* pins; top keeps the tristate.

---
 rtl/pdp8_mem_pkg.sv | 21 ++
 rtl/pdp8_mem_prio.sv | 60 ++++++
 rtl/pdp8_mem_arb.sv | 197 +++++++++++++++++++
 tb/tb_pdp8_mem_arb.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_mem_pkg.sv
// Shared types and widths for the PDP-8 SRAM arbiter.
package pdp8_mem_pkg;

  localparam int PDP8_AW = 15;
  localparam int PDP8_DW = 12;
  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

endpackage

// File: rtl/pdp8_mem_prio.sv
// Grant decision for the SRAM arbiter plus the DMA burst limiter.
// DMA normally wins, but after DMA_BURST_MAX consecutive DMA grants taken
// while the CPU was waiting, the CPU is served next.
module pdp8_mem_prio
  import pdp8_mem_pkg::*;
#(
  parameter int DMA_BURST_MAX = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   idle,
  input  logic   cpu_req,
  input  logic   dma_req,
  output logic   grant,
  output owner_t grant_owner
);

  logic [3:0] burst_reg;
  logic [3:0] burst_next;
  logic       under_limit;

  assign under_limit = (burst_reg < 4'(DMA_BURST_MAX));

  // Pick the owner while idle and work out the next burst count.
  always_comb begin
    grant       = 1'b0;
    grant_owner = OWN_CPU;
    burst_next  = burst_reg;
    if (idle) begin
      if (dma_req && under_limit) begin
        grant       = 1'b1;
        grant_owner = OWN_DMA;
      end else if (cpu_req) begin
        grant       = 1'b1;
        grant_owner = OWN_CPU;
      end else if (dma_req) begin
        grant       = 1'b1;
        grant_owner = OWN_DMA;
      end
      // Only DMA grants that make the CPU wait count towards the limit.
      if (!cpu_req) begin
        burst_next = '0;
      end else if (grant && (grant_owner == OWN_DMA)) begin
        burst_next = burst_reg + 4'd1;
      end else if (grant) begin
        burst_next = '0;
      end
    end
  end

  // Burst counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_reg <= '0;
    end else begin
      burst_reg <= burst_next;
    end
  end

endmodule

// File: rtl/pdp8_mem_arb.sv
// PDP-8 SRAM arbiter: shares the 256Kx16 SRAM between the CPU port and the
// RF08 data-break port, sequencing IDLE -> SETUP -> ACCESS -> FINISH.
// Optional build macro MEM_ARB_STATS_EN adds per-owner completion counters.
module pdp8_mem_arb
  import pdp8_mem_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int DMA_BURST_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [PDP8_AW-1:0]   cpu_addr,
  input  logic [PDP8_DW-1:0]   cpu_wdata,
  output logic [PDP8_DW-1:0]   cpu_rdata,
  output logic                 cpu_done,
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic [PDP8_AW-1:0]   dma_addr,
  input  logic [PDP8_DW-1:0]   dma_wdata,
  output logic [PDP8_DW-1:0]   dma_rdata,
  output logic                 dma_done,
  output logic [SRAM_AW-1:0]   sram_a,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic                 sram_ub_n,
  output logic                 sram_lb_n,
  output logic [SRAM_DW-1:0]   sram_dout,
  output logic                 sram_drive,
  input  logic [SRAM_DW-1:0]   sram_din
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]          stat_cpu_cnt,
  output logic [15:0]          stat_dma_cnt
`endif
);

  state_t               state_reg;
  owner_t               owner_reg;
  logic                 we_reg;
  logic [3:0]           wait_reg;
  logic [SRAM_AW-1:0]   sram_a_reg;
  logic [SRAM_DW-1:0]   sram_dout_reg;
  logic                 ce_n_reg;
  logic                 oe_n_reg;
  logic                 we_n_reg;
  logic                 drive_reg;

  logic                 grant;
  owner_t               grant_owner;
  logic                 sel_we;
  logic [PDP8_AW-1:0]   sel_addr;
  logic [PDP8_DW-1:0]   sel_wdata;
  logic                 last_access;
  logic [1:0]           done_vec;
  logic [PDP8_DW-1:0]   rdata_vec [2];
  logic                 unused_din_hi;

  pdp8_mem_prio #(
    .DMA_BURST_MAX(DMA_BURST_MAX)
  ) u_prio (
    .clk        (clk),
    .reset      (reset),
    .idle       (state_reg == IDLE),
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
    .grant      (grant),
    .grant_owner(grant_owner)
  );

  assign sel_we    = (grant_owner == OWN_DMA) ? dma_we    : cpu_we;
  assign sel_addr  = (grant_owner == OWN_DMA) ? dma_addr  : cpu_addr;
  assign sel_wdata = (grant_owner == OWN_DMA) ? dma_wdata : cpu_wdata;

  // The final ACCESS cycle: read data is sampled and FINISH follows.
  assign last_access = (state_reg == ACCESS) && (wait_reg == 4'd0);

  // Access sequencer; SRAM strobes are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_CPU;
      we_reg        <= 1'b0;
      wait_reg      <= '0;
      sram_a_reg    <= '0;
      sram_dout_reg <= '0;
      ce_n_reg      <= 1'b1;
      oe_n_reg      <= 1'b1;
      we_n_reg      <= 1'b1;
      drive_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant) begin
            owner_reg     <= grant_owner;
            we_reg        <= sel_we;
            sram_a_reg    <= {{(SRAM_AW-PDP8_AW){1'b0}}, sel_addr};
            sram_dout_reg <= {{(SRAM_DW-PDP8_DW){1'b0}}, sel_wdata};
            ce_n_reg      <= 1'b0;
            oe_n_reg      <= sel_we;
            drive_reg     <= sel_we;
            state_reg     <= SETUP;
          end
        end
        SETUP: begin
          wait_reg  <= 4'(ACCESS_CYCLES - 1);
          we_n_reg  <= ~we_reg;
          state_reg <= ACCESS;
        end
        ACCESS: begin
          if (wait_reg == 4'd0) begin
            we_n_reg  <= 1'b1;
            oe_n_reg  <= 1'b1;
            state_reg <= FINISH;
          end else begin
            wait_reg <= wait_reg - 4'd1;
          end
        end
        FINISH: begin
          // Address, data and ce were held through FINISH for write hold.
          ce_n_reg  <= 1'b1;
          drive_reg <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Per-owner completion pulse and read-data register.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_own
      localparam owner_t GI_OWNER = (gi == 0) ? OWN_CPU : OWN_DMA;
      logic               done_reg;
      logic [PDP8_DW-1:0] rdata_reg;

      // Pulse done on entry to FINISH and capture read data from the bus.
      always_ff @(posedge clk) begin
        if (reset) begin
          done_reg  <= 1'b0;
          rdata_reg <= '0;
        end else begin
          done_reg <= last_access && (owner_reg == GI_OWNER);
          if (last_access && !we_reg && (owner_reg == GI_OWNER)) begin
            rdata_reg <= sram_din[PDP8_DW-1:0];
          end
        end
      end

      assign done_vec[gi]  = done_reg;
      assign rdata_vec[gi] = rdata_reg;
    end
  endgenerate

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_vec [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
      logic [15:0] stat_reg;

      // Count completed accesses per owner; wraps naturally at 16 bits.
      always_ff @(posedge clk) begin
        if (reset) begin
          stat_reg <= '0;
        end else if (done_vec[gi]) begin
          stat_reg <= stat_reg + 16'd1;
        end
      end

      assign stat_vec[gi] = stat_reg;
    end
  endgenerate

  assign stat_cpu_cnt = stat_vec[0];
  assign stat_dma_cnt = stat_vec[1];
`endif

  // Upper data nibble is not part of the 12-bit PDP-8 word.
  assign unused_din_hi = ^sram_din[SRAM_DW-1:PDP8_DW];

  assign cpu_done   = done_vec[0];
  assign dma_done   = done_vec[1];
  assign cpu_rdata  = rdata_vec[0];
  assign dma_rdata  = rdata_vec[1];
  assign sram_a     = sram_a_reg;
  assign sram_dout  = sram_dout_reg;
  assign sram_ce_n  = ce_n_reg;
  assign sram_oe_n  = oe_n_reg;
  assign sram_we_n  = we_n_reg;
  assign sram_ub_n  = ce_n_reg;
  assign sram_lb_n  = ce_n_reg;
  assign sram_drive = drive_reg;

endmodule

// File: tb/tb_pdp8_mem_arb.sv
// Self-checking bench for pdp8_mem_arb: table vectors, hand sequences for
// burst limiting and reset mid-access, and randomized traffic against a
// transaction-level memory model. Define MEM_ARB_STATS_EN to cover stats.
`timescale 1ns/1ps
module tb_pdp8_mem_arb;

  localparam int AC      = 2;
  localparam int BMAX    = 4;
  localparam int LAT1    = 2 + AC;
  localparam int LAT2    = 2 * (2 + AC) + 1;
  localparam int TIMEOUT = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [14:0] cpu_addr, dma_addr;
  logic [11:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
  logic        cpu_done, dma_done;
  logic [17:0] sram_a;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_drive;
  logic [15:0] sram_dout, sram_din;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_cpu_cnt, stat_dma_cnt;
`endif

  pdp8_mem_arb #(.ACCESS_CYCLES(AC), .DMA_BURST_MAX(BMAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .sram_a(sram_a), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .sram_dout(sram_dout),
    .sram_drive(sram_drive), .sram_din(sram_din)
`ifdef MEM_ARB_STATS_EN
    , .stat_cpu_cnt(stat_cpu_cnt), .stat_dma_cnt(stat_dma_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // External SRAM device model
  logic [15:0] mem [0:32767];
  assign sram_din = (!sram_ce_n && !sram_oe_n) ? mem[sram_a[14:0]] : 16'hDEAD;
  always @(posedge clk) if (!sram_ce_n && !sram_we_n) mem[sram_a[14:0]] = sram_dout;

  // Reference model: 12-bit word store and last-read value per owner
  logic [11:0] ref_mem [0:32767];
  logic [11:0] m_c_rd, m_d_rd;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus protocol monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (!sram_we_n) chk("we_inside_ce_drive", {29'd0, sram_ce_n, sram_oe_n, sram_drive}, 32'b011);
      if (!sram_ce_n) chk("byte_enables_low", {30'd0, sram_ub_n, sram_lb_n}, 32'd0);
    end
  end

  // Transaction-level model: DMA is served before CPU when both request.
  task automatic model_txn(input logic c_en, d_en, c_we, d_we,
                           input logic [14:0] ca, da, input logic [11:0] cw, dw);
    if (d_en) begin
      if (d_we) ref_mem[da] = dw; else m_d_rd = ref_mem[da];
    end
    if (c_en) begin
      if (c_we) ref_mem[ca] = cw; else m_c_rd = ref_mem[ca];
    end
  endtask

  typedef struct {
    int c_lat, d_lat, ce_low, oe_low, we_low, drv_hi;
    logic [17:0] a_seen;
    logic [15:0] dout_seen;
    bit timed_out;
  } obs_t;

  task automatic run_txn(input logic c_en, d_en, c_we, d_we,
                         input logic [14:0] ca, da, input logic [11:0] cw, dw,
                         output obs_t o);
    int  t0;
    bit  c_pend, d_pend;
    @(posedge clk); #1;
    cpu_req = c_en; cpu_we = c_we; cpu_addr = ca; cpu_wdata = cw;
    dma_req = d_en; dma_we = d_we; dma_addr = da; dma_wdata = dw;
    t0 = cyc; c_pend = c_en; d_pend = d_en;
    o = '{-1, -1, 0, 0, 0, 0, 18'd0, 16'd0, 1'b0};
    for (int i = 0; i < TIMEOUT && (c_pend || d_pend); i++) begin
      @(negedge clk);
      if (!sram_ce_n) begin o.ce_low++; o.a_seen = sram_a; o.dout_seen = sram_dout; end
      if (!sram_oe_n) o.oe_low++;
      if (!sram_we_n) o.we_low++;
      if (sram_drive) o.drv_hi++;
      if (cpu_done) begin o.c_lat = cyc - t0; c_pend = 1'b0; end
      if (dma_done) begin o.d_lat = cyc - t0; d_pend = 1'b0; end
      @(posedge clk); #1;
      if (!c_pend) cpu_req = 1'b0;
      if (!d_pend) dma_req = 1'b0;
      // Inputs of the already-granted owner change; must not matter.
      if (d_en) begin dma_addr = 15'($urandom); dma_wdata = 12'($urandom); end
      else      begin cpu_addr = 15'($urandom); cpu_wdata = 12'($urandom); end
    end
    o.timed_out = c_pend || d_pend;
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  typedef struct {
    logic c_en, d_en, c_we, d_we;
    logic [14:0] c_addr, d_addr;
    logic [11:0] c_wd, d_wd;
    logic [11:0] exp_c_rd, exp_d_rd;
    int exp_c_lat, exp_d_lat;
  } vec_t;

  vec_t vecs [8];
  obs_t o;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic c_en, d_en, c_we, d_we;
    logic [14:0] ca, da;
    logic [11:0] cw, dw;
    int exp_order [6];
    int got_order [$];
    int consec, seen;
    bit cpu_wait, c_pend;

    for (int i = 0; i < 32768; i++) begin
      mem[i]     = 16'(i * 40503 + 7);
      ref_mem[i] = mem[i][11:0];
    end
    mem[15'o01234] = 16'h0ABC; ref_mem[15'o01234] = 12'hABC;
    mem[15'o00300] = 16'hF123; ref_mem[15'o00300] = 12'h123;
    m_c_rd = '0; m_d_rd = '0;

    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes_n", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
    chk("rst_drive", {31'd0, sram_drive}, 0);
    chk("rst_sram_a", {14'd0, sram_a}, 0);
    chk("rst_sram_dout", {16'd0, sram_dout}, 0);
    chk("rst_done", {30'd0, cpu_done, dma_done}, 0);
    chk("rst_rdata", {8'd0, cpu_rdata, dma_rdata}, 0);
    @(posedge clk); #1; reset = 1'b0;

    // Table vectors: {inputs, expected rdata and latencies}
    vecs[0] = '{1, 0, 0, 0, 15'o01234, 15'o00000, 12'o0000, 12'o0000, 12'o5274, 12'o0000, LAT1, -1};
    vecs[1] = '{1, 0, 1, 0, 15'o70017, 15'o00000, 12'o7777, 12'o0000, 12'o5274, 12'o0000, LAT1, -1};
    vecs[2] = '{1, 0, 0, 0, 15'o70017, 15'o00000, 12'o0000, 12'o0000, 12'o7777, 12'o0000, LAT1, -1};
    vecs[3] = '{0, 1, 0, 1, 15'o00000, 15'o00100, 12'o0000, 12'o1234, 12'o7777, 12'o0000, -1, LAT1};
    vecs[4] = '{1, 1, 1, 0, 15'o00200, 15'o00100, 12'o4321, 12'o0000, 12'o7777, 12'o1234, LAT2, LAT1};
    vecs[5] = '{1, 0, 0, 0, 15'o00200, 15'o00000, 12'o0000, 12'o0000, 12'o4321, 12'o1234, LAT1, -1};
    vecs[6] = '{1, 1, 0, 0, 15'o70017, 15'o01234, 12'o0000, 12'o0000, 12'o7777, 12'o5274, LAT2, LAT1};
    vecs[7] = '{1, 0, 0, 0, 15'o00300, 15'o00000, 12'o0000, 12'o0000, 12'o0443, 12'o5274, LAT1, -1};

    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v = vecs[i];
      run_txn(v.c_en, v.d_en, v.c_we, v.d_we, v.c_addr, v.d_addr, v.c_wd, v.d_wd, o);
      model_txn(v.c_en, v.d_en, v.c_we, v.d_we, v.c_addr, v.d_addr, v.c_wd, v.d_wd);
      $display("vec %0d: cpu(en=%0b we=%0b a=%o) dma(en=%0b we=%0b a=%o) lat=%0d/%0d rd=%o/%o",
               i, v.c_en, v.c_we, v.c_addr, v.d_en, v.d_we, v.d_addr, o.c_lat, o.d_lat, cpu_rdata, dma_rdata);
      chk($sformatf("v%0d_timeout", i), {31'd0, o.timed_out}, 0);
      chk($sformatf("v%0d_cpu_lat", i), o.c_lat, v.exp_c_lat);
      chk($sformatf("v%0d_dma_lat", i), o.d_lat, v.exp_d_lat);
      chk($sformatf("v%0d_cpu_rdata", i), {20'd0, cpu_rdata}, {20'd0, v.exp_c_rd});
      chk($sformatf("v%0d_dma_rdata", i), {20'd0, dma_rdata}, {20'd0, v.exp_d_rd});
      if (v.c_en != v.d_en) begin
        logic w;
        logic [14:0] a;
        logic [11:0] d;
        w = v.c_en ? v.c_we : v.d_we;
        a = v.c_en ? v.c_addr : v.d_addr;
        d = v.c_en ? v.c_wd : v.d_wd;
        chk($sformatf("v%0d_ce_low_cycles", i), o.ce_low, 2 + AC);
        chk($sformatf("v%0d_oe_low_cycles", i), o.oe_low, w ? 0 : 1 + AC);
        chk($sformatf("v%0d_we_low_cycles", i), o.we_low, w ? AC : 0);
        chk($sformatf("v%0d_drive_cycles", i), o.drv_hi, w ? 2 + AC : 0);
        chk($sformatf("v%0d_sram_a", i), {14'd0, o.a_seen}, {17'd0, a});
        if (w) chk($sformatf("v%0d_sram_dout", i), {16'd0, o.dout_seen}, {20'd0, d});
      end
    end

    // Burst limit: DMA held continuously while the CPU waits.
    consec = 0; cpu_wait = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (cpu_wait && consec < BMAX) begin exp_order[k] = 1; consec++; end
      else if (cpu_wait) begin exp_order[k] = 0; cpu_wait = 1'b0; consec = 0; end
      else exp_order[k] = 1;
    end
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 15'o00300;
    dma_req = 1; dma_we = 0; dma_addr = 15'o01234;
    c_pend = 1'b1;
    for (int i = 0; i < 200 && got_order.size() < 6; i++) begin
      @(negedge clk);
      if (cpu_done) begin got_order.push_back(0); c_pend = 1'b0; end
      if (dma_done) got_order.push_back(1);
      @(posedge clk); #1;
      if (!c_pend) cpu_req = 1'b0;
      if (got_order.size() >= 6) dma_req = 1'b0;
    end
    cpu_req = 0; dma_req = 0;
    chk("burst_done_count", got_order.size(), 6);
    for (int k = 0; k < 6; k++) begin
      int g;
      g = (k < got_order.size()) ? got_order[k] : -1;
      $display("burst grant %0d: owner=%s", k, (g == 0) ? "cpu" : (g == 1) ? "dma" : "none");
      chk($sformatf("burst_order_%0d", k), g, exp_order[k]);
    end
    model_txn(1, 1, 0, 0, 15'o00300, 15'o01234, 12'd0, 12'd0);
    chk("burst_cpu_rdata", {20'd0, cpu_rdata}, {20'd0, m_c_rd});
    chk("burst_dma_rdata", {20'd0, dma_rdata}, {20'd0, m_d_rd});

    // Reset in the middle of a CPU write.
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 15'o05555; cpu_wdata = 12'o1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rstmid_we_low_before", {31'd0, sram_we_n}, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; cpu_req = 0;
    @(negedge clk);
    chk("rstmid_we_n", {31'd0, sram_we_n}, 1);
    chk("rstmid_ce_n", {31'd0, sram_ce_n}, 1);
    chk("rstmid_drive", {31'd0, sram_drive}, 0);
    chk("rstmid_done", {30'd0, cpu_done, dma_done}, 0);
    chk("rstmid_cpu_rdata", {20'd0, cpu_rdata}, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_done || dma_done) seen++;
    end
    chk("rstmid_no_done", seen, 0);
    m_c_rd = '0; m_d_rd = '0;
    run_txn(1, 0, 0, 0, 15'o01234, 15'o0, 12'd0, 12'd0, o);
    model_txn(1, 0, 0, 0, 15'o01234, 15'o0, 12'd0, 12'd0);
    $display("post-reset read: lat=%0d rd=%o", o.c_lat, cpu_rdata);
    chk("rstmid_fresh_lat", o.c_lat, LAT1);
    chk("rstmid_fresh_rdata", {20'd0, cpu_rdata}, 32'o5274);
    chk("rstmid_dma_rdata", {20'd0, dma_rdata}, 0);

    // Randomized traffic against the memory model.
    for (int i = 0; i < 40; i++) begin
      int mode;
      mode = $urandom_range(0, 2);
      c_en = (mode != 1); d_en = (mode != 0);
      c_we = 1'($urandom); d_we = 1'($urandom);
      ca = {3'($urandom), 8'h00, 4'($urandom)};
      da = {3'($urandom), 8'h00, 4'($urandom)};
      cw = 12'($urandom); dw = 12'($urandom);
      run_txn(c_en, d_en, c_we, d_we, ca, da, cw, dw, o);
      model_txn(c_en, d_en, c_we, d_we, ca, da, cw, dw);
      $display("rand %0d: cpu(en=%0b we=%0b a=%o) dma(en=%0b we=%0b a=%o) lat=%0d/%0d rd=%o/%o",
               i, c_en, c_we, ca, d_en, d_we, da, o.c_lat, o.d_lat, cpu_rdata, dma_rdata);
      chk($sformatf("r%0d_timeout", i), {31'd0, o.timed_out}, 0);
      chk($sformatf("r%0d_cpu_lat", i), o.c_lat, c_en ? (d_en ? LAT2 : LAT1) : -1);
      chk($sformatf("r%0d_dma_lat", i), o.d_lat, d_en ? LAT1 : -1);
      chk($sformatf("r%0d_cpu_rdata", i), {20'd0, cpu_rdata}, {20'd0, m_c_rd});
      chk($sformatf("r%0d_dma_rdata", i), {20'd0, dma_rdata}, {20'd0, m_d_rd});
    end

`ifdef MEM_ARB_STATS_EN
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("stat_cpu_reset", {16'd0, stat_cpu_cnt}, 0);
    chk("stat_dma_reset", {16'd0, stat_dma_cnt}, 0);
    for (int i = 0; i < 3; i++) run_txn(1, 0, 0, 0, 15'o00300, 15'o0, 12'd0, 12'd0, o);
    for (int i = 0; i < 5; i++) run_txn(0, 1, 0, 0, 15'o0, 15'o01234, 12'd0, 12'd0, o);
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("stats: cpu=%0d dma=%0d", stat_cpu_cnt, stat_dma_cnt);
    chk("stat_cpu_cnt", {16'd0, stat_cpu_cnt}, 3);
    chk("stat_dma_cnt", {16'd0, stat_dma_cnt}, 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
